pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central hazard and stall controller for the 5-stage pipeline. Each cycle it decides whether the pipeline registers advance, hold, bubble or flush. It drives the IF/ID hold and flush inputs, the PC write enable, the ID/EX bubble insert, and a global freeze used while the data memory is busy. It detects load-use hazards and taken branches, sequences multi-cycle data-memory waits with a small FSM, and runs a watchdog on memory latency.

## Interface
Parameters:
- REG_W, 5, register-index width
- WAIT_W, 8, width of the memory-wait counter
- MEM_TIMEOUT, 200, wait-cycle count at which the watchdog fires; must be < 2^WAIT_W

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- id_rs_i  in  REG_W  rs of instruction in ID
- id_rt_i  in  REG_W  rt of instruction in ID
- ex_memread_i  in  1  instruction in EX is a load
- ex_rt_i  in  REG_W  load destination in EX
- id_branch_taken_i  in  1  branch in ID resolved taken
- mem_req_i  in  1  MEM stage accesses data memory this cycle
- mem_ready_i  in  1  data memory completes the access this cycle
- pc_write_o  out  1  PC update enable
- ifid_hazard_o  out  1  IF/ID hold
- ifid_flush_o  out  1  IF/ID clear
- idex_bubble_o  out  1  zero control fields entering ID/EX
- pipe_freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB
- mem_timeout_o  out  1  sticky watchdog flag
- state_o  out  1  FSM state, 0 = RUN, 1 = MEM_WAIT

## Operation
- Control outputs are Mealy: combinational from the current state and inputs, so pipeline registers sample them at the same edge. State, counters and flags are registered.
- Load-use condition `lu`: ex_memread_i && ex_rt_i != 0 && (ex_rt_i == id_rs_i || ex_rt_i == id_rt_i).
- Memory stall condition `ms`: mem_req_i && !mem_ready_i.
- Priority, highest first:
  1. reset
  2. freeze (state MEM_WAIT, or RUN with `ms`)
  3. load-use
  4. branch
  5. normal
- Output values per case:
  - Freeze: pc_write_o=0, ifid_hazard_o=1, pipe_freeze_o=1, ifid_flush_o=0, idex_bubble_o=0.
  - Load-use: pc_write_o=0, ifid_hazard_o=1, idex_bubble_o=1, everything else 0. The branch is deferred; ID re-evaluates it next cycle.
  - Branch: ifid_flush_o=1, pc_write_o=1, everything else 0.
  - Normal: pc_write_o=1, everything else 0.
- FSM transitions:
  - RUN → MEM_WAIT when `ms`.
  - MEM_WAIT → RUN when mem_ready_i. In that cycle all freeze outputs are already deasserted and normal, load-use or branch rules apply, so the pipeline advances at that edge.
  - mem_req_i is ignored while in MEM_WAIT.
- Wait counter:
  - Clears in RUN.
  - Increments each MEM_WAIT cycle and saturates at 2^WAIT_W−1.
  - When it reaches MEM_TIMEOUT, mem_timeout_o sets and stays set until rst_i. The FSM keeps waiting.
- Register index 0 never causes a load-use stall.

## Timing
- While rst_i=1: pc_write_o=0, ifid_flush_o=1, all other control outputs 0, state_o=0, mem_timeout_o=0, counters 0. Registered values take effect at the first edge with rst_i high.
- Reset during MEM_WAIT: state returns to RUN at that edge and the wait count is lost.
- Load-use costs exactly one bubble. After one cycle the load is in MEM and `lu` drops on its own; no state is kept.
- A memory access that is ready in the same cycle (mem_req_i && mem_ready_i in RUN) costs 0 stall cycles and no state change.
- An access with N not-ready cycles freezes the pipeline for exactly N cycles.
- mem_timeout_o rises the edge after the counter reaches MEM_TIMEOUT, i.e. after MEM_TIMEOUT+1 cycles in MEM_WAIT.

## Configuration
- PIPELINE_CTRL_PERF_EN defined: adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - stall_cnt_o increments on every freeze or load-use cycle.
  - flush_cnt_o increments on every branch-flush cycle.
  - Both wrap modulo 2^32 and clear on reset.
- Macro undefined: the ports and counters are absent and the remaining behaviour is identical.

## Structure
- Shared pipeline package holds:
  - state encodings ST_RUN and ST_MEM_WAIT
  - REG_W
  - a constant for register zero
- One natural sub-module, hazard_detect: the purely combinational `lu` comparator, reusable by the forwarding unit. The FSM, watchdog and counters stay in pipeline_ctrl.

## Test plan
- Reset released, no hazards → pc_write_o=1 and all other control outputs 0 every cycle. With PIPELINE_CTRL_PERF_EN defined, both counters stay 0.
- ex_memread_i=1, ex_rt_i=5, id_rs_i=5 for one cycle → exactly one cycle with pc_write_o=0, ifid_hazard_o=1, idex_bubble_o=1. Repeat with ex_rt_i=0 → no stall.
- Load-use and id_branch_taken_i asserted together → load-use outputs with ifid_flush_o=0. Next cycle, branch alone → ifid_flush_o=1 for one cycle.
- mem_req_i=1 with mem_ready_i low for 3 cycles, then high → pipe_freeze_o=1 for exactly 3 cycles, state_o=1 for cycles 2–3, back to RUN after the ready edge. stall_cnt_o=3.
- MEM_TIMEOUT=4, memory never ready → mem_timeout_o rises after 5 MEM_WAIT cycles and stays high through the eventual mem_ready_i. Only rst_i clears it.
- rst_i asserted during MEM_WAIT → next cycle state_o=0, pipe_freeze_o=0, ifid_flush_o=1 while rst_i is held.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline definitions: FSM state encodings, register-index width
// and the hard-wired zero register index.
package pipeline_ctrl_pkg;

   localparam int REG_W = 5;

   localparam logic [REG_W-1:0] REG_ZERO = '0;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use comparator; also usable by the forwarding unit.
// Register zero never produces a hazard.
module hazard_detect
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_W = pipeline_ctrl_pkg::REG_W
) (
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_rt,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   output logic             lu
);

   logic hit;

   assign hit = (ex_rt == id_rs) || (ex_rt == id_rt);
   assign lu  = ex_memread && (ex_rt != REG_W'(REG_ZERO)) && hit;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller: Mealy pipeline controls, memory-wait FSM, watchdog.
// Optional perf counters under PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_W       = pipeline_ctrl_pkg::REG_W,
   parameter int WAIT_W      = 8,
   parameter int MEM_TIMEOUT = 200
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [REG_W-1:0] id_rs_i,
   input  logic [REG_W-1:0] id_rt_i,
   input  logic             ex_memread_i,
   input  logic [REG_W-1:0] ex_rt_i,
   input  logic             id_branch_taken_i,
   input  logic             mem_req_i,
   input  logic             mem_ready_i,
   output logic             pc_write_o,
   output logic             ifid_hazard_o,
   output logic             ifid_flush_o,
   output logic             idex_bubble_o,
   output logic             pipe_freeze_o,
   output logic             mem_timeout_o,
   output logic             state_o
`ifdef PIPELINE_CTRL_PERF_EN
   ,
   output logic [31:0]      stall_cnt_o,
   output logic [31:0]      flush_cnt_o
`endif
);

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              timeout;
   logic              lu;
   logic              ms;
   logic              freeze;

   hazard_detect #(.REG_W(REG_W)) u_hazard (
      .ex_memread (ex_memread_i),
      .ex_rt      (ex_rt_i),
      .id_rs      (id_rs_i),
      .id_rt      (id_rt_i),
      .lu         (lu)
   );

   assign ms = mem_req_i && !mem_ready_i;

   // In MEM_WAIT the ready cycle already releases the pipeline.
   assign freeze = (state == ST_MEM_WAIT) ? !mem_ready_i : ms;

   always_comb begin
      pc_write_o    = 1'b1;
      ifid_hazard_o = 1'b0;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      pipe_freeze_o = 1'b0;
      priority case (1'b1)
         rst_i: begin
            pc_write_o   = 1'b0;
            ifid_flush_o = 1'b1;
         end
         freeze: begin
            pc_write_o    = 1'b0;
            ifid_hazard_o = 1'b1;
            pipe_freeze_o = 1'b1;
         end
         lu: begin
            pc_write_o    = 1'b0;
            ifid_hazard_o = 1'b1;
            idex_bubble_o = 1'b1;
         end
         id_branch_taken_i: begin
            ifid_flush_o = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= ST_RUN;
         wait_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         unique case (state)
            ST_RUN: begin
               wait_cnt <= '0;
               if (ms) state <= ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
               if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
               if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) timeout <= 1'b1;
               if (mem_ready_i) state <= ST_RUN;
            end
            default: state <= ST_RUN;
         endcase
      end
   end

   assign mem_timeout_o = timeout;
   assign state_o       = state;

`ifdef PIPELINE_CTRL_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   // Freeze and load-use both raise the IF/ID hold; reset forces it low.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (ifid_hazard_o) stall_cnt <= stall_cnt + 32'd1;
         if (ifid_flush_o)  flush_cnt <= flush_cnt + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt;
   assign flush_cnt_o = flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (MEM_TIMEOUT = 4).
// Perf counter checks compile in when PIPELINE_CTRL_PERF_EN is defined.
module tb_pipeline_ctrl;

   localparam int REG_W = 5;

   // {pc_write, ifid_hazard, ifid_flush, idex_bubble, pipe_freeze}
   localparam logic [4:0] C_NRM = 5'b10000;
   localparam logic [4:0] C_LU  = 5'b01010;
   localparam logic [4:0] C_BR  = 5'b10100;
   localparam logic [4:0] C_FRZ = 5'b01001;
   localparam logic [4:0] C_RST = 5'b00100;

   logic             clk = 1'b0;
   logic             rst_i;
   logic [REG_W-1:0] id_rs_i, id_rt_i, ex_rt_i;
   logic             ex_memread_i, id_branch_taken_i;
   logic             mem_req_i, mem_ready_i;
   logic             pc_write_o, ifid_hazard_o, ifid_flush_o;
   logic             idex_bubble_o, pipe_freeze_o;
   logic             mem_timeout_o, state_o;
   logic [4:0]       ctl;
   int               nchk = 0;
   int               nerr = 0;
`ifdef PIPELINE_CTRL_PERF_EN
   logic [31:0]      stall_cnt_o, flush_cnt_o;
   int               exp_stall = 0;
   int               exp_flush = 0;
`endif

   always #5 clk = ~clk;

   assign ctl = {pc_write_o, ifid_hazard_o, ifid_flush_o,
                 idex_bubble_o, pipe_freeze_o};

   pipeline_ctrl #(
      .REG_W(REG_W), .WAIT_W(8), .MEM_TIMEOUT(4)
   ) dut (
      .clk_i             (clk),
      .rst_i             (rst_i),
      .id_rs_i           (id_rs_i),
      .id_rt_i           (id_rt_i),
      .ex_memread_i      (ex_memread_i),
      .ex_rt_i           (ex_rt_i),
      .id_branch_taken_i (id_branch_taken_i),
      .mem_req_i         (mem_req_i),
      .mem_ready_i       (mem_ready_i),
      .pc_write_o        (pc_write_o),
      .ifid_hazard_o     (ifid_hazard_o),
      .ifid_flush_o      (ifid_flush_o),
      .idex_bubble_o     (idex_bubble_o),
      .pipe_freeze_o     (pipe_freeze_o),
      .mem_timeout_o     (mem_timeout_o),
      .state_o           (state_o)
`ifdef PIPELINE_CTRL_PERF_EN
      ,
      .stall_cnt_o       (stall_cnt_o),
      .flush_cnt_o       (flush_cnt_o)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs_i           = '0;
      id_rt_i           = '0;
      ex_rt_i           = '0;
      ex_memread_i      = 1'b0;
      id_branch_taken_i = 1'b0;
      mem_req_i         = 1'b0;
      mem_ready_i       = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      rst_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         nchk++;
         if (ctl !== C_RST) begin
            nerr++;
            $display("FAIL reset_ctl ctl=%b exp=%b", ctl, C_RST);
         end
         nchk++;
         if (state_o !== 1'b0 || mem_timeout_o !== 1'b0) begin
            nerr++;
            $display("FAIL reset_state st=%b to=%b exp=0 0", state_o, mem_timeout_o);
         end
         tick();
      end
      rst_i = 1'b0;
   endtask

   task automatic test_normal();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         nchk++;
         if (ctl !== C_NRM || state_o !== 1'b0) begin
            nerr++;
            $display("FAIL normal ctl=%b st=%b exp=%b 0", ctl, state_o, C_NRM);
         end
         tick();
      end
`ifdef PIPELINE_CTRL_PERF_EN
      nchk++;
      if (stall_cnt_o !== 32'(exp_stall) || flush_cnt_o !== 32'(exp_flush)) begin
         nerr++;
         $display("FAIL perf_idle stall=%0d flush=%0d exp=%0d %0d",
                  stall_cnt_o, flush_cnt_o, exp_stall, exp_flush);
      end
`endif
   endtask

   task automatic test_load_use();
      logic [4:0] exp;
      // {memread, ex_rt, id_rs, id_rt} -> stall?
      logic [15:0] vec [5];
      logic        stl [5];
      vec[0] = {1'b1, 5'd5, 5'd5, 5'd0};  stl[0] = 1'b1;
      vec[1] = {1'b1, 5'd7, 5'd3, 5'd7};  stl[1] = 1'b1;
      vec[2] = {1'b1, 5'd0, 5'd0, 5'd0};  stl[2] = 1'b0;
      vec[3] = {1'b0, 5'd5, 5'd5, 5'd5};  stl[3] = 1'b0;
      vec[4] = {1'b1, 5'd9, 5'd8, 5'd10}; stl[4] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         {ex_memread_i, ex_rt_i, id_rs_i, id_rt_i} = vec[i];
         exp = stl[i] ? C_LU : C_NRM;
         @(negedge clk);
         nchk++;
         if (ctl !== exp) begin
            nerr++;
            $display("FAIL load_use[%0d] ctl=%b exp=%b", i, ctl, exp);
         end
`ifdef PIPELINE_CTRL_PERF_EN
         if (stl[i]) exp_stall++;
`endif
         tick();
         idle();
         @(negedge clk);
         nchk++;
         if (ctl !== C_NRM) begin
            nerr++;
            $display("FAIL load_use_after[%0d] ctl=%b exp=%b", i, ctl, C_NRM);
         end
         tick();
      end
   endtask

   task automatic test_branch_defer();
      ex_memread_i = 1'b1; ex_rt_i = 5'd4; id_rs_i = 5'd4;
      id_branch_taken_i = 1'b1;
      @(negedge clk);
      nchk++;
      if (ctl !== C_LU) begin
         nerr++;
         $display("FAIL branch_lu ctl=%b exp=%b", ctl, C_LU);
      end
      tick();
      ex_memread_i = 1'b0; ex_rt_i = '0; id_rs_i = '0;
      @(negedge clk);
      nchk++;
      if (ctl !== C_BR) begin
         nerr++;
         $display("FAIL branch_flush ctl=%b exp=%b", ctl, C_BR);
      end
      tick();
      idle();
      @(negedge clk);
      nchk++;
      if (ctl !== C_NRM) begin
         nerr++;
         $display("FAIL branch_after ctl=%b exp=%b", ctl, C_NRM);
      end
`ifdef PIPELINE_CTRL_PERF_EN
      exp_stall++;
      exp_flush++;
`endif
      tick();
   endtask

   task automatic test_mem_wait();
      logic st_exp [3];
      st_exp[0] = 1'b0; st_exp[1] = 1'b1; st_exp[2] = 1'b1;
      mem_req_i = 1'b1; mem_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         nchk++;
         if (ctl !== C_FRZ || state_o !== st_exp[i]) begin
            nerr++;
            $display("FAIL mem_wait[%0d] ctl=%b st=%b exp=%b %b",
                     i, ctl, state_o, C_FRZ, st_exp[i]);
         end
         tick();
      end
      mem_ready_i = 1'b1;
      @(negedge clk);
      nchk++;
      if (ctl !== C_NRM || state_o !== 1'b1) begin
         nerr++;
         $display("FAIL mem_ready ctl=%b st=%b exp=%b 1", ctl, state_o, C_NRM);
      end
      tick();
      idle();
      @(negedge clk);
      nchk++;
      if (ctl !== C_NRM || state_o !== 1'b0 || mem_timeout_o !== 1'b0) begin
         nerr++;
         $display("FAIL mem_back ctl=%b st=%b to=%b exp=%b 0 0",
                  ctl, state_o, mem_timeout_o, C_NRM);
      end
`ifdef PIPELINE_CTRL_PERF_EN
      exp_stall += 3;
      nchk++;
      if (stall_cnt_o !== 32'(exp_stall)) begin
         nerr++;
         $display("FAIL perf_stall got=%0d exp=%0d", stall_cnt_o, exp_stall);
      end
`endif
      tick();
   endtask

   task automatic test_back_to_back();
      mem_req_i = 1'b1; mem_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         nchk++;
         if (ctl !== C_NRM || state_o !== 1'b0) begin
            nerr++;
            $display("FAIL mem_fast[%0d] ctl=%b st=%b exp=%b 0",
                     i, ctl, state_o, C_NRM);
         end
         tick();
      end
      idle();
   endtask

   task automatic test_timeout();
      mem_req_i = 1'b1; mem_ready_i = 1'b0;
      tick();
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         nchk++;
         if (mem_timeout_o !== 1'b0 || ctl !== C_FRZ) begin
            nerr++;
            $display("FAIL timeout_early[%0d] to=%b ctl=%b exp=0 %b",
                     i, mem_timeout_o, ctl, C_FRZ);
         end
         tick();
      end
      @(negedge clk);
      nchk++;
      if (mem_timeout_o !== 1'b1 || state_o !== 1'b1) begin
         nerr++;
         $display("FAIL timeout_rise to=%b st=%b exp=1 1", mem_timeout_o, state_o);
      end
      tick();
      mem_ready_i = 1'b1;
      @(negedge clk);
      nchk++;
      if (ctl !== C_NRM || mem_timeout_o !== 1'b1) begin
         nerr++;
         $display("FAIL timeout_ready ctl=%b to=%b exp=%b 1", ctl, mem_timeout_o, C_NRM);
      end
      tick();
      idle();
      tick();
      @(negedge clk);
      nchk++;
      if (state_o !== 1'b0 || mem_timeout_o !== 1'b1) begin
         nerr++;
         $display("FAIL timeout_sticky st=%b to=%b exp=0 1", state_o, mem_timeout_o);
      end
`ifdef PIPELINE_CTRL_PERF_EN
      exp_stall += 7;
      nchk++;
      if (stall_cnt_o !== 32'(exp_stall)) begin
         nerr++;
         $display("FAIL perf_timeout got=%0d exp=%0d", stall_cnt_o, exp_stall);
      end
`endif
      tick();
   endtask

   task automatic test_reset_mem_wait();
      mem_req_i = 1'b1; mem_ready_i = 1'b0;
      tick();
      mem_req_i = 1'b0;
      rst_i = 1'b1;
      @(negedge clk);
      nchk++;
      if (ctl !== C_RST || state_o !== 1'b1) begin
         nerr++;
         $display("FAIL rst_in_wait ctl=%b st=%b exp=%b 1", ctl, state_o, C_RST);
      end
      tick();
      @(negedge clk);
      nchk++;
      if (ctl !== C_RST || state_o !== 1'b0 || mem_timeout_o !== 1'b0) begin
         nerr++;
         $display("FAIL rst_after_wait ctl=%b st=%b to=%b exp=%b 0 0",
                  ctl, state_o, mem_timeout_o, C_RST);
      end
`ifdef PIPELINE_CTRL_PERF_EN
      exp_stall = 0;
      exp_flush = 0;
      nchk++;
      if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
         nerr++;
         $display("FAIL perf_reset stall=%0d flush=%0d exp=0 0",
                  stall_cnt_o, flush_cnt_o);
      end
`endif
      tick();
      rst_i = 1'b0;
      @(negedge clk);
      nchk++;
      if (ctl !== C_NRM || state_o !== 1'b0) begin
         nerr++;
         $display("FAIL rst_release ctl=%b st=%b exp=%b 0", ctl, state_o, C_NRM);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_normal();
      test_load_use();
      test_branch_defer();
      test_mem_wait();
      test_back_to_back();
      test_timeout();
      test_reset_mem_wait();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
